// File: rtl/lpm_pkg.sv
// Shared low-power-mode constants: LPM state encoding, lpm_mode bit positions,
// and the clock-module control bit defines these requests feed.
package lpm_pkg;

    typedef enum logic [1:0] {
        LPM_ACTIVE = 2'd0,
        LPM_ENTER  = 2'd1,
        LPM_SLEEP  = 2'd2,
        LPM_WAKE   = 2'd3
    } lpm_state_e;

    // lpm_mode bit positions
    localparam int SCG1_BIT   = 0;
    localparam int OSCOFF_BIT = 1;

    // clock-module control register bit defines
    localparam int CLK_CPUOFF_BIT = 4;
    localparam int CLK_OSCOFF_BIT = 5;
    localparam int CLK_SCG0_BIT   = 6;
    localparam int CLK_SCG1_BIT   = 7;

    function automatic logic mode_scg1(input logic [1:0] mode);
        return mode[SCG1_BIT];
    endfunction

    function automatic logic mode_oscoff(input logic [1:0] mode);
        return mode[OSCOFF_BIT];
    endfunction

endpackage

// File: rtl/lpm_ctrl.sv
// Low-power-mode sequencer: gates the CPU clock, requests SMCLK/LFXT shutdown
// while asleep, and holds the CPU off for a fixed settle time after wake-up.
//
// state  | meaning
// ACTIVE | CPU running, clocks on
// ENTER  | sleep requested, waiting for the bus to drain
// SLEEP  | CPU stopped, latched lpm_mode drives scg1/oscoff
// WAKE   | clocks restarting, CPU held off for WAKE_CYC cycles
module lpm_ctrl
    import lpm_pkg::*;
#(
    parameter int WAKE_CYC = 4,
    parameter int CNT_W    = 4
) (
    input  logic       mclk,
    input  logic       puc_n,
    input  logic       sleep_req,
    input  logic [1:0] lpm_mode,
    input  logic       bus_idle,
    input  logic       wkup,
    input  logic       dbg_wkup,
    output logic       mclk_en,
    output logic       scg1,
    output logic       oscoff,
    output logic       sleeping,
    output logic       wake_pulse,
    output logic [1:0] lpm_state
);

    localparam logic [CNT_W-1:0] WAKE_LOAD = CNT_W'(WAKE_CYC - 1);

    lpm_state_e       state_q;
    lpm_state_e       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [1:0]       mode_q;
    logic [1:0]       mode_d;
    logic             wake_req;

    logic             mclk_en_d;
    logic             scg1_d;
    logic             oscoff_d;
    logic             sleeping_d;
    logic             wake_pulse_d;

    assign wake_req = wkup | dbg_wkup;

    always_ff @(posedge mclk) begin
        if (!puc_n) begin
            state_q <= LPM_ACTIVE;
            cnt_q   <= '0;
            mode_q  <= 2'b00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        case (state_q)
            LPM_ACTIVE: begin
                if (sleep_req && !wake_req) begin
                    state_d = LPM_ENTER;
                end
            end
            LPM_ENTER: begin
                // a pending wake beats a drained bus
                if (wake_req) begin
                    state_d = LPM_ACTIVE;
                end else if (bus_idle) begin
                    state_d = LPM_SLEEP;
                    mode_d  = lpm_mode;
                end
            end
            LPM_SLEEP: begin
                if (wake_req) begin
                    state_d = LPM_WAKE;
                    cnt_d   = WAKE_LOAD;
                end
            end
            LPM_WAKE: begin
                if (cnt_q == '0) begin
                    state_d = LPM_ACTIVE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = LPM_ACTIVE;
            end
        endcase
    end

    // outputs are decoded from the next state so they register alongside it
    always_comb begin
        mclk_en_d    = 1'b1;
        scg1_d       = 1'b0;
        oscoff_d     = 1'b0;
        sleeping_d   = 1'b0;
        wake_pulse_d = 1'b0;
        case (state_d)
            LPM_SLEEP: begin
                mclk_en_d  = 1'b0;
                scg1_d     = mode_scg1(mode_d);
                oscoff_d   = mode_oscoff(mode_d);
                sleeping_d = 1'b1;
            end
            LPM_WAKE: begin
                mclk_en_d = 1'b0;
            end
            LPM_ACTIVE: begin
                wake_pulse_d = (state_q == LPM_WAKE);
            end
            default: begin
                mclk_en_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge mclk) begin
        if (!puc_n) begin
            mclk_en    <= 1'b1;
            scg1       <= 1'b0;
            oscoff     <= 1'b0;
            sleeping   <= 1'b0;
            wake_pulse <= 1'b0;
        end else begin
            mclk_en    <= mclk_en_d;
            scg1       <= scg1_d;
            oscoff     <= oscoff_d;
            sleeping   <= sleeping_d;
            wake_pulse <= wake_pulse_d;
        end
    end

    assign lpm_state = state_q;

endmodule

// File: tb/tb_lpm_ctrl.sv
// Self-checking bench for lpm_ctrl: directed scenarios plus randomized traffic
// compared cycle by cycle against a behavioural model.
module tb_lpm_ctrl;

    localparam int WAKE_CYC = 4;
    localparam int CNT_W    = 4;

    logic       mclk = 1'b0;
    logic       puc_n = 1'b0;
    logic       sleep_req = 1'b0;
    logic [1:0] lpm_mode = 2'b00;
    logic       bus_idle = 1'b0;
    logic       wkup = 1'b0;
    logic       dbg_wkup = 1'b0;
    logic       mclk_en;
    logic       scg1;
    logic       oscoff;
    logic       sleeping;
    logic       wake_pulse;
    logic [1:0] lpm_state;

    int n_chk  = 0;
    int n_fail = 0;

    // model: phase 0..3 per the spec encoding, cycles spent in WAKE so far
    int         m_phase   = 0;
    int         m_elapsed = 0;
    logic [1:0] m_mode    = 2'b00;
    logic       m_pulse   = 1'b0;

    logic [6:0] obs;
    assign obs = {lpm_state, mclk_en, scg1, oscoff, sleeping, wake_pulse};

    localparam logic [6:0] V_ACTIVE = 7'b00_1_0000;
    localparam logic [6:0] V_PULSE  = 7'b00_1_0001;
    localparam logic [6:0] V_ENTER  = 7'b01_1_0000;
    localparam logic [6:0] V_WAKE   = 7'b11_0_0000;
    localparam logic [6:0] V_SLP01  = 7'b10_0_1010;
    localparam logic [6:0] V_SLP11  = 7'b10_0_1110;

    lpm_ctrl #(.WAKE_CYC(WAKE_CYC), .CNT_W(CNT_W)) dut (
        .mclk      (mclk),
        .puc_n     (puc_n),
        .sleep_req (sleep_req),
        .lpm_mode  (lpm_mode),
        .bus_idle  (bus_idle),
        .wkup      (wkup),
        .dbg_wkup  (dbg_wkup),
        .mclk_en   (mclk_en),
        .scg1      (scg1),
        .oscoff    (oscoff),
        .sleeping  (sleeping),
        .wake_pulse(wake_pulse),
        .lpm_state (lpm_state)
    );

    always #5 mclk = ~mclk;

    function automatic logic [6:0] model_vec();
        logic [1:0] ph;
        ph = m_phase[1:0];
        return {ph, (m_phase < 2), (m_phase == 2) && m_mode[0],
                (m_phase == 2) && m_mode[1], (m_phase == 2), m_pulse};
    endfunction

    task automatic tick();
        @(posedge mclk);
        m_pulse = 1'b0;
        if (!puc_n) begin
            m_phase   = 0;
            m_elapsed = 0;
            m_mode    = 2'b00;
        end else if (m_phase == 0) begin
            if (sleep_req && !wkup && !dbg_wkup) m_phase = 1;
        end else if (m_phase == 1) begin
            if (wkup || dbg_wkup) m_phase = 0;
            else if (bus_idle) begin
                m_phase = 2;
                m_mode  = lpm_mode;
            end
        end else if (m_phase == 2) begin
            if (wkup || dbg_wkup) begin
                m_phase   = 3;
                m_elapsed = 1;
            end
        end else begin
            if (m_elapsed >= WAKE_CYC) begin
                m_phase = 0;
                m_pulse = 1'b1;
            end else begin
                m_elapsed++;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        puc_n = 1'b0;
        tick();
        tick();
        n_chk++;
        if (obs !== V_ACTIVE) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b want %b", obs, V_ACTIVE);
        end
        puc_n = 1'b1;
        tick();
        n_chk++;
        if (obs !== V_ACTIVE) begin
            n_fail++;
            $display("FAIL reset_idle: got %b want %b", obs, V_ACTIVE);
        end
    endtask

    task automatic test_enter_sleep();
        sleep_req = 1'b1;
        lpm_mode  = 2'b01;
        bus_idle  = 1'b1;
        tick();
        n_chk++;
        if (obs !== V_ENTER) begin
            n_fail++;
            $display("FAIL enter_state: got %b want %b", obs, V_ENTER);
        end
        tick();
        sleep_req = 1'b0;
        n_chk++;
        if (obs !== V_SLP01) begin
            n_fail++;
            $display("FAIL sleep_mode01: got %b want %b", obs, V_SLP01);
        end
        tick();
        n_chk++;
        if (obs !== V_SLP01) begin
            n_fail++;
            $display("FAIL sleep_hold: got %b want %b", obs, V_SLP01);
        end
    endtask

    task automatic run_wake(input bit use_dbg, input string tag);
        if (use_dbg) dbg_wkup = 1'b1;
        else         wkup     = 1'b1;
        tick();
        wkup     = 1'b0;
        dbg_wkup = 1'b0;
        for (int i = 0; i < WAKE_CYC; i++) begin
            n_chk++;
            if (obs !== V_WAKE) begin
                n_fail++;
                $display("FAIL %s_wake_cyc%0d: got %b want %b", tag, i, obs, V_WAKE);
            end
            tick();
        end
        n_chk++;
        if (obs !== V_PULSE) begin
            n_fail++;
            $display("FAIL %s_wake_pulse: got %b want %b", tag, obs, V_PULSE);
        end
        tick();
        n_chk++;
        if (obs !== V_ACTIVE) begin
            n_fail++;
            $display("FAIL %s_after_pulse: got %b want %b", tag, obs, V_ACTIVE);
        end
    endtask

    task automatic test_wake();
        run_wake(1'b0, "wkup");
    endtask

    task automatic test_enter_abort();
        sleep_req = 1'b1;
        bus_idle  = 1'b0;
        tick();
        sleep_req = 1'b0;
        for (int i = 0; i < 10; i++) begin
            n_chk++;
            if (obs !== V_ENTER) begin
                n_fail++;
                $display("FAIL abort_enter_hold%0d: got %b want %b", i, obs, V_ENTER);
            end
            tick();
        end
        wkup = 1'b1;
        bus_idle = 1'b1;
        n_chk++;
        if (obs !== V_ENTER) begin
            n_fail++;
            $display("FAIL abort_enter_last: got %b want %b", obs, V_ENTER);
        end
        tick();
        wkup = 1'b0;
        n_chk++;
        if (obs !== V_ACTIVE) begin
            n_fail++;
            $display("FAIL abort_to_active: got %b want %b", obs, V_ACTIVE);
        end
    endtask

    task automatic test_simultaneous();
        sleep_req = 1'b1;
        wkup      = 1'b1;
        bus_idle  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_chk++;
            if (obs !== V_ACTIVE) begin
                n_fail++;
                $display("FAIL simul_stay%0d: got %b want %b", i, obs, V_ACTIVE);
            end
        end
        wkup = 1'b0;
        tick();
        n_chk++;
        if (obs !== V_ENTER) begin
            n_fail++;
            $display("FAIL simul_enter: got %b want %b", obs, V_ENTER);
        end
        sleep_req = 1'b0;
        dbg_wkup  = 1'b1;
        tick();
        dbg_wkup = 1'b0;
        n_chk++;
        if (obs !== V_ACTIVE) begin
            n_fail++;
            $display("FAIL simul_dbg_abort: got %b want %b", obs, V_ACTIVE);
        end
    endtask

    task automatic test_reset_in_wake();
        sleep_req = 1'b1;
        bus_idle  = 1'b1;
        lpm_mode  = 2'b11;
        tick();
        tick();
        sleep_req = 1'b0;
        wkup = 1'b1;
        tick();
        wkup = 1'b0;
        tick();
        n_chk++;
        if (obs !== V_WAKE) begin
            n_fail++;
            $display("FAIL rstwake_second: got %b want %b", obs, V_WAKE);
        end
        puc_n = 1'b0;
        tick();
        puc_n = 1'b1;
        n_chk++;
        if (obs !== V_ACTIVE) begin
            n_fail++;
            $display("FAIL rstwake_reset: got %b want %b", obs, V_ACTIVE);
        end
        for (int i = 0; i < WAKE_CYC + 2; i++) begin
            tick();
            n_chk++;
            if (obs !== V_ACTIVE) begin
                n_fail++;
                $display("FAIL rstwake_no_pulse%0d: got %b want %b", i, obs, V_ACTIVE);
            end
        end
    endtask

    task automatic test_mode_hold();
        sleep_req = 1'b1;
        bus_idle  = 1'b1;
        lpm_mode  = 2'b11;
        tick();
        tick();
        sleep_req = 1'b0;
        lpm_mode  = 2'b00;
        for (int i = 0; i < 5; i++) begin
            n_chk++;
            if (obs !== V_SLP11) begin
                n_fail++;
                $display("FAIL modehold%0d: got %b want %b", i, obs, V_SLP11);
            end
            tick();
        end
        run_wake(1'b1, "dbg");
    endtask

    task automatic test_random();
        logic [6:0] exp_v;
        for (int i = 0; i < 3000; i++) begin
            puc_n     = ($urandom_range(0, 63) != 0);
            sleep_req = ($urandom_range(0, 2) != 0);
            lpm_mode  = 2'($urandom_range(0, 3));
            bus_idle  = ($urandom_range(0, 1) != 0);
            wkup      = ($urandom_range(0, 9) == 0);
            dbg_wkup  = ($urandom_range(0, 19) == 0);
            tick();
            exp_v = model_vec();
            n_chk++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL random_cyc%0d: got %b want %b", i, obs, exp_v);
            end
        end
        puc_n     = 1'b1;
        sleep_req = 1'b0;
        wkup      = 1'b0;
        dbg_wkup  = 1'b0;
    endtask

    initial begin
        #2;
        test_reset();
        test_enter_sleep();
        test_wake();
        test_enter_abort();
        test_simultaneous();
        test_reset_in_wake();
        test_mode_hold();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
